// File: rtl/fc_soc_event_fifo.sv
// Per-source event pending counters, a round-robin arbiter and a small FIFO that
// delivers event IDs to the FC event FIFO interface (valid / data / fulln).
module fc_soc_event_fifo #(
    parameter int unsigned NB_SRC         = 8,
    parameter int unsigned EVENT_ID_WIDTH = 8,
    parameter int unsigned EVT_BASE       = 0,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned PEND_W         = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NB_SRC-1:0]         evt_i,
    input  logic                      clr_ovf_i,
    output logic                      fc_fifo_valid_o,
    output logic [EVENT_ID_WIDTH-1:0] fc_fifo_data_o,
    input  logic                      fc_fifo_fulln_i,
    output logic [NB_SRC-1:0]         pend_ovf_o,
    output logic [$clog2(DEPTH):0]    fifo_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0]         cnt_q [NB_SRC];
    logic [PEND_W-1:0]         cnt_d [NB_SRC];
    logic [NB_SRC-1:0]         ovf_q, ovf_d, ovf_set;
    logic [SW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [EVENT_ID_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q, count_d;

    logic                      cand_vld;
    logic [SW-1:0]             cand_idx;
    logic [SW:0]               scan_sum;
    logic [SW-1:0]             scan_idx;
    logic                      fifo_full;
    logic                      push, pop;
    logic [EVENT_ID_WIDTH-1:0] push_id;

    // First non-empty source searching upward from rr_ptr+1, modulo NB_SRC.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= NB_SRC; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (scan_sum >= (SW+1)'(NB_SRC)) begin
                scan_sum = scan_sum - (SW+1)'(NB_SRC);
            end
            scan_idx = scan_sum[SW-1:0];
            if (!cand_vld && (cnt_q[scan_idx] != '0)) begin
                cand_vld = 1'b1;
                cand_idx = scan_idx;
            end
        end
    end

    // Full is judged on registered occupancy so a same-cycle pop never frees a slot.
    assign fifo_full       = (count_q == CW'(DEPTH));
    assign push            = cand_vld && !fifo_full;
    assign push_id         = EVENT_ID_WIDTH'(EVT_BASE) + EVENT_ID_WIDTH'(cand_idx);
    assign fc_fifo_valid_o = (count_q != '0);
    assign pop             = fc_fifo_valid_o && fc_fifo_fulln_i;
    assign fc_fifo_data_o  = fc_fifo_valid_o ? mem_q[rd_ptr_q] : '0;
    assign fifo_count_o    = count_q;
    assign pend_ovf_o      = ovf_q;

    always_comb begin
        ovf_set = '0;
        for (int unsigned i = 0; i < NB_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (evt_i[i] && !(push && (cand_idx == SW'(i)))) begin
                if (cnt_q[i] == PEND_MAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!evt_i[i] && push && (cand_idx == SW'(i))) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        // A new overflow in the same cycle as a clear keeps its flag.
        ovf_d    = (clr_ovf_i ? '0 : ovf_q) | ovf_set;
        rr_ptr_d = push ? cand_idx : rr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NB_SRC; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q    <= '0;
            rr_ptr_q <= SW'(NB_SRC - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NB_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q    <= ovf_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the output is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

endmodule

// File: tb/tb_fc_soc_event_fifo.sv
// Scoreboard bench for fc_soc_event_fifo: a queue-based reference model predicts
// delivered IDs, occupancy and overflow flags; a negedge monitor compares.
module tb_fc_soc_event_fifo;

    localparam int NB     = 8;
    localparam int BASE   = 16;
    localparam int DEPTH  = 4;
    localparam int PMAX   = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] evt = '0;
    logic       clr = 1'b0;
    logic       fulln = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic [7:0] ovf;
    logic [2:0] count;

    fc_soc_event_fifo #(
        .NB_SRC         (NB),
        .EVENT_ID_WIDTH (8),
        .EVT_BASE       (BASE),
        .DEPTH          (DEPTH),
        .PEND_W         (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .evt_i           (evt),
        .clr_ovf_i       (clr),
        .fc_fifo_valid_o (valid),
        .fc_fifo_data_o  (data),
        .fc_fifo_fulln_i (fulln),
        .pend_ovf_o      (ovf),
        .fifo_count_o    (count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    // Reference model: pending counts as integers, FIFO as a queue.
    int         pend [NB];
    int         rr;
    logic [7:0] m_ovf;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         m_pop, m_full, m_found, m_grant;
    int         m_g;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) pend[i] = 0;
            rr = NB - 1;
            m_ovf = '0;
            mq.delete();
            exp_q.delete();
        end else begin
            m_pop   = (mq.size() != 0) && fulln;
            m_full  = (mq.size() == DEPTH);
            m_found = 0;
            m_g     = 0;
            for (int k = 1; k <= NB; k++) begin
                if (!m_found && pend[(rr + k) % NB] > 0) begin
                    m_found = 1;
                    m_g = (rr + k) % NB;
                end
            end
            m_grant = m_found && !m_full;
            if (m_pop) void'(mq.pop_front());
            if (m_grant) begin
                mq.push_back(8'(BASE + m_g));
                exp_q.push_back(8'(BASE + m_g));
                rr = m_g;
            end
            if (clr) m_ovf = '0;
            for (int i = 0; i < NB; i++) begin
                if (evt[i] && !(m_grant && m_g == i)) begin
                    if (pend[i] == PMAX) m_ovf[i] = 1'b1;
                    else pend[i]++;
                end else if (!evt[i] && m_grant && m_g == i) begin
                    pend[i]--;
                end
            end
        end
    end

    // Monitor: compares state every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", {31'b0, valid}, {31'b0, mq.size() != 0});
            check("count", {29'b0, count}, mq.size());
            check("ovf", {24'b0, ovf}, {24'b0, m_ovf});
            if (valid) begin
                check("sb_nonempty", {31'b0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    check("data", {24'b0, data}, {24'b0, exp_q[0]});
                    if (fulln) begin
                        got_q.push_back(data);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("data_idle", {24'b0, data}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        evt = '0;
        clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int pos;
    int n12;

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst_data", {24'b0, data}, 0);
        check("rst_ovf", {24'b0, ovf}, 0);
        check("rst_count", {29'b0, count}, 0);

        // Single pulse on source 3: valid two cycles later with ID 0x13
        do_reset();
        fulln = 1'b1;
        tick();
        evt = 8'h08;
        tick();
        evt = '0;
        @(negedge clk);
        check("lat_n1_valid", {31'b0, valid}, 0);
        @(negedge clk);
        check("lat_n2_valid", {31'b0, valid}, 1);
        check("lat_n2_data", {24'b0, data}, 32'h13);
        @(negedge clk);
        check("lat_n3_count", {29'b0, count}, 0);

        // All sources in one cycle: delivered in order 0..7
        do_reset();
        got_q.delete();
        tick();
        evt = '1;
        tick();
        evt = '0;
        repeat (14) tick();
        check("all_n", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check("all_order", {24'b0, got_q[i]}, BASE + i);

        // Saturation: fulln low, 20 pulses on source 2, 19 delivered
        do_reset();
        got_q.delete();
        fulln = 1'b0;
        repeat (20) begin
            tick();
            evt = 8'h04;
        end
        tick();
        evt = '0;
        @(negedge clk);
        check("sat_ovf2", {31'b0, ovf[2]}, 1);
        check("sat_count", {29'b0, count}, 4);
        tick();
        fulln = 1'b1;
        repeat (40) tick();
        n12 = 0;
        foreach (got_q[i]) if (got_q[i] == 8'h12) n12++;
        check("sat_delivered", n12, 19);
        check("sat_total", got_q.size(), 19);

        // Overflow clear alone, then clear colliding with a new overflow
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_alone", {31'b0, ovf[2]}, 0);
        fulln = 1'b0;
        repeat (19) begin
            tick();
            evt = 8'h04;
        end
        tick();
        evt = 8'h04;
        clr = 1'b1;
        tick();
        evt = '0;
        clr = 1'b0;
        @(negedge clk);
        check("clr_vs_set", {31'b0, ovf[2]}, 1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_again", {31'b0, ovf[2]}, 0);
        fulln = 1'b1;
        repeat (40) tick();

        // No starvation: source 5 every cycle, source 1 once
        do_reset();
        got_q.delete();
        fulln = 1'b1;
        tick();
        evt = 8'h20;
        repeat (3) tick();
        evt = 8'h22;
        tick();
        evt = 8'h20;
        repeat (30) tick();
        evt = '0;
        repeat (40) tick();
        pos = -1;
        foreach (got_q[i]) if (pos < 0 && got_q[i] == 8'h11) pos = i;
        check("starve_seen", {31'b0, pos >= 0}, 1);
        check("starve_bound", {31'b0, pos >= 0 && pos <= 4 + NB}, 1);

        // Asynchronous reset with count=3 and pending events
        do_reset();
        fulln = 1'b0;
        tick();
        evt = 8'h1F;
        tick();
        evt = '0;
        repeat (3) tick();
        @(negedge clk);
        check("pre_rst_count", {29'b0, count}, 3);
        #1 rst = 1'b1;
        #1;
        check("async_valid", {31'b0, valid}, 0);
        check("async_count", {29'b0, count}, 0);
        tick();
        tick();
        rst = 1'b0;
        fulln = 1'b1;
        got_q.delete();
        repeat (10) tick();
        check("no_stale", got_q.size(), 0);

        // Randomized traffic against the model
        do_reset();
        repeat (1500) begin
            tick();
            evt   = 8'($urandom & $urandom);
            fulln = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 15) == 0);
        end
        tick();
        evt = '0;
        clr = 1'b0;
        fulln = 1'b1;
        repeat (200) tick();
        check("drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
